// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window scheduler: pixel width,
// default engine latency and the scheduler FSM state encoding.
package conv_pkg;

    localparam int PIX_W            = 8;
    localparam int PIPE_LAT_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer, one 16-bit entry per column: {row r-2, row r-1}.
// Combinational read and synchronous write share one address each cycle.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 640
)(
    input  logic                                    clk,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] i_addr,
    input  logic                                    i_wr_en,
    input  logic [2*PIX_W-1:0]                      i_wr_data,
    output logic [2*PIX_W-1:0]                      o_rd_data
);

    logic [2*PIX_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; priming rewrites every column.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_addr];

endmodule

// File: rtl/conv_window_scheduler.sv
// Streams a raster frame into two line buffers and issues 3-row column
// triples to a convolution engine under downstream credit flow control.
// Optional: define CONV_SCHED_BORDER_EN to add the o_conv_border output.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int PIPE_LAT    = PIPE_LAT_DEFAULT,
    parameter int OUT_CREDITS = 16
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_pix_valid,
    input  logic [PIX_W-1:0]   i_pix,
    output logic               o_pix_ready,
    output logic               o_conv_valid,
    output logic [3*PIX_W-1:0] o_conv_data,
    output logic               o_conv_done,
    input  logic               i_out_pop,
    output logic               o_busy,
    output logic               o_frame_done
`ifdef CONV_SCHED_BORDER_EN
    ,
    output logic               o_conv_border
`endif
);

    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CRED_W  = $clog2(OUT_CREDITS + 1);
    localparam int DRAIN_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    state_t               r_state;
    state_t               w_next_state;
    logic [COL_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [CRED_W-1:0]    r_credits;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_conv_valid;
    logic                 r_conv_done;
    logic [3*PIX_W-1:0]   r_conv_data;
    logic                 w_accept;
    logic                 w_run_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_frame_last;
    logic                 w_cred_full;
    logic [2*PIX_W-1:0]   w_rd_data;
    logic [2*PIX_W-1:0]   w_wr_data;

    assign w_accept     = i_pix_valid && o_pix_ready;
    assign w_run_accept = w_accept && (r_state == RUN);
    assign w_col_last   = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last   = (r_row == ROW_W'(IMG_H - 1));
    assign w_frame_last = w_col_last && w_row_last;
    assign w_cred_full  = (r_credits == CRED_W'(OUT_CREDITS));
    assign w_wr_data    = {w_rd_data[PIX_W-1:0], i_pix};

    conv_line_buffer #(
        .DEPTH     (IMG_W)
    ) u_line_buffer (
        .clk       (clk),
        .i_addr    (r_col),
        .i_wr_en   (w_accept),
        .i_wr_data (w_wr_data),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (i_start) w_next_state = PRIME;
            PRIME: if (w_accept && (r_row == ROW_W'(1)) && w_col_last) w_next_state = RUN;
            RUN:   if (w_run_accept && w_frame_last) w_next_state = DRAIN;
            DRAIN: if (r_drain_cnt == DRAIN_W'(PIPE_LAT)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready  = 1'b0;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        case (r_state)
            PRIME: begin
                o_pix_ready = 1'b1;
                o_busy      = 1'b1;
            end
            RUN: begin
                o_pix_ready = (r_credits != '0);
                o_busy      = 1'b1;
            end
            DRAIN: begin
                o_busy       = 1'b1;
                o_frame_done = (r_drain_cnt == DRAIN_W'(PIPE_LAT));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE && i_start)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // A credit is spent when a pixel is accepted in RUN, so ready drops
    // before the buffer can be over-committed by the one-cycle issue delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits <= CRED_W'(OUT_CREDITS);
        end else if (w_run_accept && !i_out_pop) begin
            r_credits <= r_credits - CRED_W'(1);
        end else if (!w_run_accept && i_out_pop && !w_cred_full) begin
            r_credits <= r_credits + CRED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state != DRAIN)) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conv_valid <= 1'b0;
            r_conv_done  <= 1'b0;
            r_conv_data  <= '0;
        end else begin
            r_conv_valid <= w_run_accept;
            r_conv_done  <= w_run_accept && w_frame_last;
            if (w_run_accept) begin
                r_conv_data <= {w_rd_data, i_pix};
            end
        end
    end

    assign o_conv_valid = r_conv_valid;
    assign o_conv_done  = r_conv_done;
    assign o_conv_data  = r_conv_data;

`ifdef CONV_SCHED_BORDER_EN
    logic r_conv_border;

    // Columns 0 and 1 lack a full 3-wide horizontal neighbourhood.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conv_border <= 1'b0;
        end else begin
            r_conv_border <= w_run_accept && (r_col < COL_W'(2));
        end
    end

    assign o_conv_border = r_conv_border;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed self-checking bench for conv_window_scheduler on a 4x4 frame
// with a two-entry downstream credit pool.
module tb_conv_window_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        pixValid;
    logic [7:0]  pix;
    logic        pixReady;
    logic        convValid;
    logic [23:0] convData;
    logic        convDone;
    logic        outPop;
    logic        busy;
    logic        frameDone;
`ifdef CONV_SCHED_BORDER_EN
    logic        convBorder;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nextPix = 1;

    logic [23:0] issueQ[$];
    logic        borderQ[$];
    int          doneCnt = 0;
    int          frameDoneCnt = 0;
    int          doneCyc = 0;
    int          frameDoneCyc = 0;
    logic [23:0] doneData = '0;

    conv_window_scheduler #(
        .IMG_W        (4),
        .IMG_H        (4),
        .PIPE_LAT     (9),
        .OUT_CREDITS  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_pix_valid  (pixValid),
        .i_pix        (pix),
        .o_pix_ready  (pixReady),
        .o_conv_valid (convValid),
        .o_conv_data  (convData),
        .o_conv_done  (convDone),
        .i_out_pop    (outPop),
        .o_busy       (busy),
        .o_frame_done (frameDone)
`ifdef CONV_SCHED_BORDER_EN
        ,
        .o_conv_border (convBorder)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Issue log sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (convValid) begin
            issueQ.push_back(convData);
`ifdef CONV_SCHED_BORDER_EN
            borderQ.push_back(convBorder);
`endif
        end
        if (convDone) begin
            doneCnt++;
            doneCyc = cyc;
            doneData = convData;
        end
        if (frameDone) begin
            frameDoneCnt++;
            frameDoneCyc = cyc;
        end
    end

    // Pixel at (row, col) of the 4x4 raster is row*4+col+1; issue k covers row 2+k/4.
    function automatic logic [23:0] expWin(input int k);
        int r;
        int c;
        r = 2 + k / 4;
        c = k % 4;
        return {8'((r - 2) * 4 + c + 1), 8'((r - 1) * 4 + c + 1), 8'(r * 4 + c + 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        issueQ.delete();
        borderQ.delete();
        doneCnt = 0;
        frameDoneCnt = 0;
        doneCyc = 0;
        frameDoneCyc = 0;
        doneData = '0;
    endtask

    task automatic startFrame();
        nextPix = 1;
        pix = 8'd1;
        pixValid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feedN(input int k);
        int got = 0;
        int budget = 0;
        bit acc;
        while (got < k && budget < 200) begin
            acc = pixValid && pixReady;
            tick();
            budget++;
            if (acc) begin
                got++;
                nextPix++;
                pix = 8'(nextPix);
                if (nextPix > 16) pixValid = 1'b0;
            end
        end
        checks++;
        if (got != k) begin
            errors++;
            $display("[TB] FAIL feed_timeout: accepted %0d pixels, required %0d", got, k);
        end
    endtask

    task automatic waitFrameDone(input int budget);
        int n = 0;
        while (frameDoneCnt == 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        pixValid = 1'b0;
        pix = '0;
        outPop = 1'b0;
        repeat (3) tick();
        checks++;
        if ({pixReady, convValid, convDone, busy, frameDone} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 00000", {pixReady, convValid, convDone, busy, frameDone});
        end
        checks++;
        if (convData !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h required 000000", convData);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || pixReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy %b ready %b required 0 0", busy, pixReady);
        end
    endtask

    task automatic test_full_frame();
        int borderCnt = 0;
        outPop = 1'b1;
        clearLog();
        startFrame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_prime: got %b required 1", busy);
        end
        feedN(16);
        waitFrameDone(40);
        checks++;
        if (issueQ.size() != 8) begin
            errors++;
            $display("[TB] FAIL frame_issue_count: got %0d required 8", issueQ.size());
        end
        for (int k = 0; k < 8 && k < issueQ.size(); k++) begin
            checks++;
            if (issueQ[k] !== expWin(k)) begin
                errors++;
                $display("[TB] FAIL frame_data[%0d]: got %h required %h", k, issueQ[k], expWin(k));
            end
        end
        checks++;
        if (doneCnt != 1 || doneData !== 24'h080C10) begin
            errors++;
            $display("[TB] FAIL conv_done: count %0d data %h required 1 080c10", doneCnt, doneData);
        end
        checks++;
        if (frameDoneCnt != 1 || (frameDoneCyc - doneCyc) != 9) begin
            errors++;
            $display("[TB] FAIL frame_done_delay: count %0d delay %0d required 1 9", frameDoneCnt, frameDoneCyc - doneCyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_after_frame: got %b required 0", busy);
        end
`ifdef CONV_SCHED_BORDER_EN
        for (int k = 0; k < borderQ.size(); k++) begin
            if (borderQ[k]) borderCnt++;
            checks++;
            if (borderQ[k] !== ((k % 4) < 2)) begin
                errors++;
                $display("[TB] FAIL border[%0d]: got %b required %b", k, borderQ[k], (k % 4) < 2);
            end
        end
        checks++;
        if (borderCnt != 4) begin
            errors++;
            $display("[TB] FAIL border_count: got %0d required 4", borderCnt);
        end
`endif
    endtask

    task automatic test_credit_stall();
        outPop = 1'b0;
        clearLog();
        startFrame();
        feedN(10);
        repeat (10) tick();
        checks++;
        if (issueQ.size() != 2 || pixReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_no_credit: issues %0d ready %b required 2 0", issueQ.size(), pixReady);
        end
        outPop = 1'b1;
        tick();
        outPop = 1'b0;
        feedN(1);
        repeat (10) tick();
        checks++;
        if (issueQ.size() != 3 || pixReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pop: issues %0d ready %b required 3 0", issueQ.size(), pixReady);
        end
        outPop = 1'b1;
        feedN(5);
        waitFrameDone(40);
        checks++;
        if (issueQ.size() != 8 || frameDoneCnt != 1) begin
            errors++;
            $display("[TB] FAIL stall_frame_end: issues %0d frame_done %0d required 8 1", issueQ.size(), frameDoneCnt);
        end
        checks++;
        if (issueQ.size() == 8 && issueQ[7] !== expWin(7)) begin
            errors++;
            $display("[TB] FAIL stall_last_data: got %h required %h", issueQ[7], expWin(7));
        end
    endtask

    task automatic test_pop_and_issue();
        outPop = 1'b0;
        clearLog();
        startFrame();
        feedN(9);
        checks++;
        if (pixReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL credit_one_ready: got %b required 1", pixReady);
        end
        outPop = 1'b1;
        feedN(1);
        outPop = 1'b0;
        checks++;
        if (pixReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pop_issue_same_cycle: ready %b required 1", pixReady);
        end
        feedN(1);
        checks++;
        if (pixReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL credit_exhausted: ready %b required 0", pixReady);
        end
        outPop = 1'b1;
        feedN(5);
        waitFrameDone(40);
        checks++;
        if (issueQ.size() != 8 || doneCnt != 1) begin
            errors++;
            $display("[TB] FAIL pop_frame_end: issues %0d done %0d required 8 1", issueQ.size(), doneCnt);
        end
    endtask

    task automatic test_start_ignored();
        outPop = 1'b1;
        clearLog();
        startFrame();
        feedN(10);
        start = 1'b1;
        feedN(2);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_run: got %b required 1", busy);
        end
        feedN(4);
        waitFrameDone(40);
        checks++;
        if (issueQ.size() != 8 || frameDoneCnt != 1 || doneData !== expWin(7)) begin
            errors++;
            $display("[TB] FAIL start_in_run: issues %0d frame_done %0d done_data %h required 8 1 %h", issueQ.size(), frameDoneCnt, doneData, expWin(7));
        end
    endtask

    task automatic test_reset_mid_frame();
        outPop = 1'b1;
        clearLog();
        startFrame();
        feedN(10);
        reset = 1'b1;
        tick();
        checks++;
        if ({pixReady, convValid, convDone, busy, frameDone} !== 5'b0 || convData !== 24'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: ctrl %b data %h required 00000 000000", {pixReady, convValid, convDone, busy, frameDone}, convData);
        end
        reset = 1'b0;
        pixValid = 1'b0;
        clearLog();
        repeat (30) tick();
        checks++;
        if (doneCnt != 0 || frameDoneCnt != 0 || issueQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL abandoned_frame: done %0d frame_done %0d issues %0d required 0 0 0", doneCnt, frameDoneCnt, issueQ.size());
        end
        clearLog();
        startFrame();
        feedN(16);
        waitFrameDone(40);
        checks++;
        if (issueQ.size() != 8) begin
            errors++;
            $display("[TB] FAIL restart_issue_count: got %0d required 8", issueQ.size());
        end
        for (int k = 0; k < 8 && k < issueQ.size(); k++) begin
            checks++;
            if (issueQ[k] !== expWin(k)) begin
                errors++;
                $display("[TB] FAIL restart_data[%0d]: got %h required %h", k, issueQ[k], expWin(k));
            end
        end
        checks++;
        if (frameDoneCnt != 1 || (frameDoneCyc - doneCyc) != 9) begin
            errors++;
            $display("[TB] FAIL restart_frame_done: count %0d delay %0d required 1 9", frameDoneCnt, frameDoneCyc - doneCyc);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_credit_stall();
        test_pop_and_issue();
        test_start_ignored();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
